dmem_lsu: RTL and testbench

- Parametrised successor to the single-cycle word data memory.
- Word-organised RAM behind a valid/ready request/response interface.
- Supports RV32I load/store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW) with byte-lane writes and sign/zero extension.
- Configurable response latency, base-address window, and misalignment/range fault reporting.
- Sits between the pipeline MEM stage and storage; the MEM stage stalls while a request is outstanding.

---
 rtl/dmem_lsu.sv | 134 +++++++++++++
 tb/tb_dmem_lsu.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// Word-organised data memory with a valid/ready request/response interface,
// RV32I byte/half/word loads and stores, a configurable response latency and fault reporting.
module dmem_lsu #(
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned LATENCY   = 1,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CW   = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [31:0] SPAN = 32'(DEPTH * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          lat_we;
  logic [2:0]    lat_f3;
  logic [31:0]   lat_addr, lat_wdata;
  logic [31:0]   mem [DEPTH];

  logic          accept, commit, fault;
  logic [31:0]   off, word, sh_b, sh_h, wr_data, ld_data;
  logic [3:0]    wr_mask;
  logic [AW-1:0] idx;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;
  // The WAIT cycle with a zero count is the one whose closing edge commits.
  assign commit     = (state == WAIT) && (cnt == '0);

  assign off  = lat_addr - BASE_ADDR;
  assign idx  = off[AW+1:2];
  assign word = mem[idx];
  assign sh_b = word >> {lat_addr[1:0], 3'b000};
  assign sh_h = word >> {lat_addr[1], 4'b0000};

  always_comb begin
    case (lat_f3)
      3'b000:  fault = 1'b0;
      3'b001:  fault = lat_addr[0];
      3'b010:  fault = (lat_addr[1:0] != 2'b00);
      3'b100:  fault = lat_we;
      3'b101:  fault = lat_we | lat_addr[0];
      default: fault = 1'b1;
    endcase
    if (off >= SPAN) fault = 1'b1;
  end

  always_comb begin
    wr_mask = '0;
    wr_data = lat_wdata;
    ld_data = '0;
    case (lat_f3[1:0])
      2'b00: begin
        wr_mask = 4'b0001 << lat_addr[1:0];
        wr_data = {4{lat_wdata[7:0]}};
        ld_data = lat_f3[2] ? {24'h0, sh_b[7:0]} : {{24{sh_b[7]}}, sh_b[7:0]};
      end
      2'b01: begin
        wr_mask = lat_addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{lat_wdata[15:0]}};
        ld_data = lat_f3[2] ? {16'h0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      end
      2'b10: begin
        wr_mask = '1;
        ld_data = word;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lat_we     <= 1'b0;
      lat_f3     <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        lat_we    <= req_we;
        lat_f3    <= req_funct3;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= CW'(LATENCY - 1);
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - CW'(1);
      end
      if (commit) begin
        resp_fault <= fault;
        resp_rdata <= (fault || lat_we) ? '0 : ld_data;
      end
    end
  end

  // Reset forces state out of WAIT asynchronously, so an aborted store never reaches here.
  always_ff @(posedge clk) begin
    if (commit && lat_we && !fault) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wr_mask[i]) mem[idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (latency 1, latency 3, offset base) driven with
// directed and random transactions, checked against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_dmem_lsu;

  localparam int N     = 3;
  localparam int DEPTH = 64;
  localparam int          LAT  [N] = '{1, 3, 2};
  localparam logic [31:0] BASE [N] = '{32'h0000_0000, 32'h0000_0000, 32'h1000_0000};

  logic        clk = 1'b0;
  logic        reset      [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        req_we     [N];
  logic [2:0]  req_funct3 [N];
  logic [31:0] req_addr   [N];
  logic [31:0] req_wdata  [N];
  logic        resp_valid [N];
  logic        resp_ready [N];
  logic [31:0] resp_rdata [N];
  logic        resp_fault [N];

  logic [7:0]  mref [N][DEPTH*4];
  int          vectors = 0;
  int          errors  = 0;

  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(64), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u0 (
    .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_rdata(resp_rdata[0]), .resp_fault(resp_fault[0]));

  dmem_lsu #(.DEPTH(64), .LATENCY(3), .BASE_ADDR(32'h0000_0000)) u1 (
    .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_rdata(resp_rdata[1]), .resp_fault(resp_fault[1]));

  dmem_lsu #(.DEPTH(64), .LATENCY(2), .BASE_ADDR(32'h1000_0000)) u2 (
    .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_we(req_we[2]), .req_funct3(req_funct3[2]), .req_addr(req_addr[2]),
    .req_wdata(req_wdata[2]), .resp_valid(resp_valid[2]), .resp_ready(resp_ready[2]),
    .resp_rdata(resp_rdata[2]), .resp_fault(resp_fault[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit ref_fault(input int d, input bit we, input logic [2:0] f3,
                                   input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE[d];
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
    if (we && (f3 == 3'd4 || f3 == 3'd5)) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (addr % 2) != 0) return 1'b1;
    if (f3 == 3'd2 && (addr % 4) != 0) return 1'b1;
    return off >= 32'(DEPTH * 4);
  endfunction

  function automatic logic [31:0] ref_load(input int d, input logic [2:0] f3,
                                           input logic [31:0] addr);
    int o, s;
    logic [31:0] v;
    o = int'(addr - BASE[d]);
    case (f3)
      3'd0:    begin s = $signed(mref[d][o]); v = s; end
      3'd4:    v = {24'h0, mref[d][o]};
      3'd1:    begin s = $signed({mref[d][o+1], mref[d][o]}); v = s; end
      3'd5:    v = {16'h0, mref[d][o+1], mref[d][o]};
      default: v = {mref[d][o+3], mref[d][o+2], mref[d][o+1], mref[d][o]};
    endcase
    return v;
  endfunction

  task automatic ref_store(input int d, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int o, n;
    o = int'(addr - BASE[d]);
    n = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) mref[d][o+i] = wdata[8*i +: 8];
  endtask

  task automatic xact(input int d, input bit we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, output logic [31:0] rd);
    bit          exp_f;
    logic [31:0] exp_rd;
    int          n;
    exp_f  = ref_fault(d, we, f3, addr);
    exp_rd = (exp_f || we) ? 32'h0 : ref_load(d, f3, addr);
    check("req_ready_idle", req_ready[d], 1);
    req_valid[d] = 1'b1; req_we[d] = we; req_funct3[d] = f3;
    req_addr[d]  = addr; req_wdata[d] = wdata;
    @(posedge clk); #1;
    req_valid[d] = 1'b0; req_we[d] = 1'($urandom); req_funct3[d] = 3'($urandom);
    req_addr[d]  = $urandom; req_wdata[d] = $urandom;
    check("req_ready_busy", req_ready[d], 0);
    n = 0;
    while (!resp_valid[d] && n < LAT[d] + 4) begin
      resp_ready[d] = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    resp_ready[d] = 1'b0;
    check("latency", n, LAT[d]);
    check("rdata", resp_rdata[d], exp_rd);
    check("fault", resp_fault[d], exp_f);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check("hold_valid", resp_valid[d], 1);
      check("hold_rdata", resp_rdata[d], exp_rd);
      check("hold_fault", resp_fault[d], exp_f);
      check("hold_req_ready", req_ready[d], 0);
    end
    rd = resp_rdata[d];
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
    check("released_valid", resp_valid[d], 0);
    check("released_ready", req_ready[d], 1);
    if (we && !exp_f) ref_store(d, f3, addr, wdata);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, old, a;
    logic [2:0]  f3;
    bit          we;
    for (int d = 0; d < N; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_funct3[d] = '0;
      req_addr[d] = '0; req_wdata[d] = '0; resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < N; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_rdata", resp_rdata[d], 0);
      check("rst_fault", resp_fault[d], 0);
      reset[d] = 1'b0;
    end
    @(posedge clk); #1;

    for (int d = 0; d < N; d++)
      for (int w = 0; w < DEPTH; w++)
        xact(d, 1'b1, 3'd2, BASE[d] + 32'(w * 4), $urandom, 0, rd);

    xact(0, 1, 3'd2, 32'h8, 32'hDEADBEEF, 0, rd);
    xact(0, 0, 3'd2, 32'h8, 0, 0, rd);  check("lw_deadbeef", rd, 32'hDEADBEEF);
    xact(0, 1, 3'd0, 32'h9, 32'h7F, 0, rd);
    xact(0, 1, 3'd1, 32'hA, 32'h8001, 1, rd);
    xact(0, 0, 3'd2, 32'h8, 0, 0, rd);  check("lw_merged", rd, 32'h80017FEF);
    xact(0, 0, 3'd0, 32'h9, 0, 0, rd);  check("lb_pos", rd, 32'h0000007F);
    xact(0, 0, 3'd1, 32'hA, 0, 0, rd);  check("lh_neg", rd, 32'hFFFF8001);
    xact(0, 0, 3'd5, 32'hA, 0, 0, rd);  check("lhu", rd, 32'h00008001);
    xact(0, 0, 3'd4, 32'hB, 0, 0, rd);  check("lbu", rd, 32'h00000080);
    xact(0, 0, 3'd2, 32'h6, 0, 0, rd);
    xact(0, 1, 3'd1, 32'h5, 32'hFFFF, 0, rd);
    xact(0, 0, 3'd2, 32'h4, 0, 0, rd);
    xact(0, 1, 3'd2, 32'h100, 32'h1, 0, rd);
    xact(0, 0, 3'd3, 32'h8, 0, 0, rd);
    xact(0, 1, 3'd4, 32'h8, 32'h55, 0, rd);
    xact(0, 0, 3'd2, 32'h8, 0, 0, rd);  check("after_faults", rd, 32'h80017FEF);

    xact(1, 0, 3'd2, 32'h20, 0, 4, rd);
    old = ref_load(1, 3'd2, 32'h20);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'd2;
    req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    reset[1] = 1'b1; #1;
    check("rst_mid_valid", resp_valid[1], 0);
    check("rst_mid_ready", req_ready[1], 1);
    #2 reset[1] = 1'b0;
    repeat (LAT[1] + 2) @(posedge clk);
    #1;
    check("rst_no_resp", resp_valid[1], 0);
    xact(1, 0, 3'd2, 32'h20, 0, 0, rd);  check("rst_old_data", rd, old);

    xact(2, 1, 3'd2, 32'h1000_0004, 32'hA5A5A5A5, 0, rd);
    xact(2, 0, 3'd2, 32'h1000_0004, 0, 0, rd);  check("base_lw", rd, 32'hA5A5A5A5);
    xact(2, 0, 3'd2, 32'h0000_0004, 0, 0, rd);

    for (int d = 0; d < N; d++) begin
      for (int k = 0; k < 150; k++) begin
        f3 = 3'($urandom_range(0, 7));
        we = 1'($urandom_range(0, 1));
        a  = BASE[d] + 32'($urandom_range(0, DEPTH * 4 + 15));
        if ($urandom_range(0, 3) != 0)
          a = a & ~((f3[1:0] == 2'd2) ? 32'd3 : (f3[1:0] == 2'd1) ? 32'd1 : 32'd0);
        if ($urandom_range(0, 15) == 0) a = $urandom;
        xact(d, we, f3, a, $urandom, $urandom_range(0, (d == 1) ? 4 : 2), rd);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
